rot_cmd_fifo: RTL
=================

Name: rot_cmd_fifo

Overview:
- Command buffer directly upstream of the combinational rotator datapath.
- Queues rotate commands {operand, rotate amount, direction} from a producer via valid/ready.
- Presents the oldest command first-word-fall-through on outputs that drive the rotator's i_a/i_k/i_left inputs.
- Absorbs producer bursts and consumer stalls so no command is dropped or duplicated.

Parameters:
BW_DATA, 8, operand width; matches rotator BW_DATA
BW_CTRL, 3, rotate-amount width; matches rotator BW_CTRL
DEPTH, 4, number of entries; must be a power of 2, >= 2
BW_PTR, 2, pointer width; must equal log2(DEPTH)

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rstn  input  1  synchronous active-low reset
i_valid  input  1  producer has a command on i_a/i_k/i_left
o_ready  output  1  FIFO can accept a command this cycle
i_a  input  BW_DATA  operand to rotate
i_k  input  BW_CTRL  rotate amount
i_left  input  1  direction (1: left, 0: right)
o_valid  output  1  head command present
i_ready  input  1  consumer accepts head this cycle
o_a  output  BW_DATA  head operand, to rotator i_a
o_k  output  BW_CTRL  head amount, to rotator i_k
o_left  output  1  head direction, to rotator i_left
o_count  output  BW_PTR+1  entries held, 0..DEPTH
o_full  output  1  o_count == DEPTH
o_empty  output  1  o_count == 0

Behaviour:
Clock and reset:
- One clock (i_clk). Reset is synchronous and active-low (i_rstn).
- i_rstn low at a rising edge: write pointer, read pointer and count clear to 0.
- Reset dominates any push or pop in the same cycle; all queued commands are discarded (reset mid-operation included).
- Storage array is not reset.
- Output values after reset: o_valid=0, o_empty=1, o_full=0, o_count=0, o_ready=1, o_a=0, o_k=0, o_left=0.

Handshake and pointers:
- push = i_valid & o_ready. pop = o_valid & i_ready.
- o_ready = ~o_full. No push-through when full, even if a pop occurs in the same cycle; o_ready stays combinationally independent of i_ready.
- o_valid = ~o_empty.
- Push: entry {i_a, i_k, i_left} written at wptr; wptr increments modulo DEPTH (natural wrap of BW_PTR bits).
- Pop: rptr increments modulo DEPTH.
- Count: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged, both pointers advance.

Timing and data:
- Command pushed into an empty FIFO at edge N appears on outputs with o_valid=1 after edge N (1-cycle latency). No combinational path from i_valid/i_a to o_valid/o_a.
- Head outputs are a combinational read of entry rptr, gated to all-zero when o_valid=0.
- Head outputs stay stable while o_valid=1 and i_ready=0.
- Payload is passed bit-exact; no interpretation of i_k (k=0 is a legal command).
- Commands leave in strict arrival order.

Boundary conditions:
- Full with i_valid=1: no write, pointers unchanged, command stays held by producer.
- Empty with i_ready=1: no pop, rptr unchanged.
- Pointer wrap from DEPTH-1 to 0 is seamless; ordering is preserved across the wrap.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_count=0, o_a=0, o_k=0, o_left=0.
- Push {a=8'hB4, k=3, left=1} with i_ready=0 -> next cycle o_valid=1, o_a=8'hB4, o_k=3, o_left=1, o_count=1; outputs held for 5 stall cycles.
- Push 4 commands (a=8'h01,8'h02,8'h04,8'h08) with i_ready=0 -> o_full=1, o_ready=0; a 5th command with a=8'h10 is not accepted (o_count stays 4); then i_ready=1 -> pops return 01,02,04,08 in order, followed by 10 after it is accepted.
- From count=2, hold i_valid=1 and i_ready=1 for 10 cycles with incrementing a -> o_count stays 2, output order matches input order across pointer wrap.
- Fill to count=3, drive i_rstn=0 for one edge with i_valid=1 -> o_count=0, o_valid=0; the command presented during reset is not stored.
- Chain o_a/o_k/o_left into the rotator with random traffic and random i_ready (2000 commands) -> each popped result equals the behavioural rotate of the matching pushed command, with no loss or duplication.

Source files
------------

// File: rtl/rot_cmd_fifo.sv
// rot_cmd_fifo: first-word-fall-through queue of rotate commands feeding the rotator
// Ports: i_clk/i_rstn clock and sync active-low reset; i_valid/o_ready/i_a/i_k/i_left
// producer side; o_valid/i_ready/o_a/o_k/o_left head command (zero when empty);
// o_count/o_full/o_empty occupancy.
module rot_cmd_fifo #(
   parameter int BW_DATA = 8,
   parameter int BW_CTRL = 3,
   parameter int DEPTH   = 4,
   parameter int BW_PTR  = 2
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [BW_DATA-1:0] i_a,
   input  logic [BW_CTRL-1:0] i_k,
   input  logic               i_left,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [BW_DATA-1:0] o_a,
   output logic [BW_CTRL-1:0] o_k,
   output logic               o_left,
   output logic [BW_PTR:0]    o_count,
   output logic               o_full,
   output logic               o_empty
);
   localparam logic [BW_PTR:0] FULL_CNT = (BW_PTR+1)'(DEPTH);
   logic [BW_DATA+BW_CTRL:0] mem [DEPTH];
   logic [BW_PTR-1:0] wptr, rptr;
   logic [BW_PTR:0] count;
   logic push, pop;
   assign o_full  = count == FULL_CNT;
   assign o_empty = count == '0;
   assign o_ready = ~o_full;
   assign o_valid = ~o_empty;
   assign o_count = count;
   assign push    = i_valid & o_ready;
   assign pop     = o_valid & i_ready;
   assign {o_a, o_k, o_left} = o_valid ? mem[rptr] : '0;
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
      end
   end
   // storage is deliberately not reset; stale entries are hidden by the pointers
   always_ff @(posedge i_clk)
      if (push) mem[wptr] <= {i_a, i_k, i_left};
endmodule
